ahb_bridge_sched: RTL
=====================

AHB_BRIDGE_SCHED -- requirements
Module: ahb_bridge_sched

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 3: idle (Hreadyin=0) cycles inserted after every transfer.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum WAIT cycles before abort.
REQ-003 SHALL have parameters ADDR_LO = 32'h8000_0000 and ADDR_HI = 32'h8C00_0000: legal address window [ADDR_LO, ADDR_HI).
REQ-004 SHALL have one clock and a synchronous, active-high reset; no other clock or reset exists.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous reset, active high.
REQ-007 m_req  in  2  per-requester request; held until gnt.
REQ-008 m_write  in  2  per-requester direction, 1 = write.
REQ-009 m_addr  in  2x32  per-requester address.
REQ-010 m_wdata  in  2x32  per-requester write data.
REQ-011 m_gnt  out  2  one-cycle grant pulse.
REQ-012 m_done  out  2  one-cycle completion pulse.
REQ-013 m_err  out  1  error qualifier, valid with m_done.
REQ-014 m_rdata  out  32  read data, valid with m_done of a read.
REQ-015 Hwrite, Hreadyin  out  1 each; Haddr, Hwdata  out  32 each; Htrans  out  2: bridge AHB inputs.
REQ-016 Hreadyout  in  1; Hresp  in  2; Hrdata  in  32: bridge AHB outputs.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT, GAP, REJECT.
REQ-018 IDLE: if any m_req, arbitrate round-robin (last-granted loses a tie; after reset requester 0 wins), latch winner's write/addr/wdata, go to ISSUE next cycle, or to REJECT if addr is outside the window.
REQ-019 ISSUE (one cycle): Hreadyin=1, Hwrite/Haddr/Hwdata = latched values, m_gnt[winner]=1; next state WAIT.
REQ-020 WAIT: Hreadyin=0; on Hreadyout=1 capture Hrdata and Hresp, go to GAP; counter reaching TIMEOUT also goes to GAP with error.
REQ-021 m_done[winner] SHALL pulse in the first GAP cycle; m_err=1 if Hresp!=2'b00 or timeout; m_rdata = captured Hrdata for reads, unchanged for writes.
REQ-022 GAP: Hreadyin=0 for exactly GAP_CYCLES cycles, then IDLE.
REQ-023 REJECT (one cycle): m_gnt, m_done, m_err asserted together for the winner; no bridge transfer (Hreadyin stays 0); next state IDLE; round-robin pointer updated.
REQ-024 Htrans SHALL be 2'b10 in every cycle, including reset.
REQ-025 Hwrite, Haddr, Hwdata SHALL hold the last issued values whenever Hreadyin=0.
REQ-026 Minimum issue-to-issue spacing SHALL be 3+GAP_CYCLES cycles (ISSUE, 1 WAIT, GAP, IDLE), giving at least 3 idle cycles around every write-to-read or read-to-write turnaround.
REQ-027 A requester deasserting m_req before gnt SHALL be ignored if it does not win in IDLE; requests arriving outside IDLE wait.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 On rst=1: state IDLE; m_gnt, m_done, m_err, Hreadyin, Hwrite = 0; Haddr, Hwdata, m_rdata = 0; Htrans = 2'b10; counters 0; pointer favours requester 0.
REQ-030 Reset mid-transfer SHALL drop the transfer with no m_done pulse.

Structure
REQ-031 Package ahb_bridge_pkg SHALL hold the state enum, HTRANS_NONSEQ, HRESP_OKAY and the default address window constants.
REQ-032 Round-robin selection SHALL be a sub-module ahb_rr_arb2 (req[1:0], advance, last pointer -> one-hot grant).

Verification
REQ-033 Single write, req0, addr 32'h8000_0010, data 32'hA5A5_0001, Hreadyout=1 two cycles after ISSUE -> one Hreadyin pulse carrying those values, m_done[0] with m_err=0, next ISSUE no earlier than 6 cycles later.
REQ-034 Simultaneous req0 write / req1 read 32'h8400_0020 -> req0 granted first, req1 issued after GAP of 3 idle cycles; m_rdata equals Hrdata 32'h1234_5678 at m_done[1].
REQ-035 Both requesters held continuously for 4 transfers -> grants alternate 0,1,0,1.
REQ-036 Addr 32'h8C00_0000 -> REJECT: gnt, done, err same cycle, Hreadyin never asserted.
REQ-037 Hreadyout held 0 -> m_done with m_err=1 after 16 WAIT cycles; Hresp=2'b01 -> m_err=1.
REQ-038 rst asserted during WAIT -> no m_done, all outputs at reset values next cycle.

Source files
------------

// File: rtl/ahb_bridge_pkg.sv
// Shared types and constants for the two-requester AHB bridge scheduler.
package ahb_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_GAP    = 3'd3,
        ST_REJECT = 3'd4
    } state_e;

    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0]  HRESP_OKAY    = 2'b00;
    localparam logic [31:0] ADDR_LO_DEF   = 32'h8000_0000;
    localparam logic [31:0] ADDR_HI_DEF   = 32'h8C00_0000;

    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (addr >= lo) && (addr < hi);
    endfunction

endpackage

// File: rtl/ahb_rr_arb2.sv
// Two-way round-robin arbiter; the last-granted requester loses a tie.
module ahb_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_q, last_d;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        last_d = last_q;
        if (advance && (|req)) last_d = gnt[1];
    end

    // Pointer starts at requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end

endmodule

// File: rtl/ahb_bridge_sched.sv
// Schedules single transfers from two requesters onto an AHB bridge port,
// with a fixed idle gap after every transfer and a WAIT timeout.
//   state  | meaning
//   IDLE   | arbitrate pending requests
//   ISSUE  | one-cycle Hreadyin pulse with the latched transfer
//   WAIT   | wait for Hreadyout or timeout
//   GAP    | GAP_CYCLES forced idle cycles, m_done on the first
//   REJECT | out-of-window address: gnt/done/err together
module ahb_bridge_sched
    import ahb_bridge_pkg::*;
#(
    parameter int          GAP_CYCLES = 3,
    parameter int          TIMEOUT    = 16,
    parameter logic [31:0] ADDR_LO    = ADDR_LO_DEF,
    parameter logic [31:0] ADDR_HI    = ADDR_HI_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      m_req,
    input  logic [1:0]      m_write,
    input  logic [1:0][31:0] m_addr,
    input  logic [1:0][31:0] m_wdata,
    output logic [1:0]      m_gnt,
    output logic [1:0]      m_done,
    output logic            m_err,
    output logic [31:0]     m_rdata,
    output logic            Hwrite,
    output logic            Hreadyin,
    output logic [31:0]     Haddr,
    output logic [31:0]     Hwdata,
    output logic [1:0]      Htrans,
    input  logic            Hreadyout,
    input  logic [1:0]      Hresp,
    input  logic [31:0]     Hrdata
);

    localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              win_q, win_d;
    logic              hwrite_q, hwrite_d;
    logic              hreadyin_q, hreadyin_d;
    logic [31:0]       haddr_q, haddr_d;
    logic [31:0]       hwdata_q, hwdata_d;
    logic [1:0]        m_gnt_q, m_gnt_d;
    logic [1:0]        m_done_q, m_done_d;
    logic              m_err_q, m_err_d;
    logic [31:0]       m_rdata_q, m_rdata_d;

    logic [1:0]        arb_gnt;
    logic              arb_adv;
    logic              arb_idx;

    assign arb_adv = (state_q == ST_IDLE) && (|m_req);
    assign arb_idx = arb_gnt[1];

    ahb_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (m_req),
        .advance (arb_adv),
        .gnt     (arb_gnt)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        win_d      = win_q;
        hwrite_d   = hwrite_q;
        haddr_d    = haddr_q;
        hwdata_d   = hwdata_q;
        hreadyin_d = 1'b0;
        m_gnt_d    = 2'b00;
        m_done_d   = 2'b00;
        m_err_d    = 1'b0;
        m_rdata_d  = m_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (|m_req) begin
                    win_d   = arb_idx;
                    m_gnt_d = arb_gnt;
                    if (in_window(m_addr[arb_idx], ADDR_LO, ADDR_HI)) begin
                        state_d    = ST_ISSUE;
                        hreadyin_d = 1'b1;
                        hwrite_d   = m_write[arb_idx];
                        haddr_d    = m_addr[arb_idx];
                        hwdata_d   = m_wdata[arb_idx];
                    end else begin
                        // Bus outputs keep the last issued transfer.
                        state_d  = ST_REJECT;
                        m_done_d = arb_gnt;
                        m_err_d  = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = WAIT_LOAD;
            end
            ST_WAIT: begin
                if (Hreadyout) begin
                    state_d  = ST_GAP;
                    cnt_d    = GAP_LOAD;
                    m_done_d = win_q ? 2'b10 : 2'b01;
                    m_err_d  = (Hresp != HRESP_OKAY);
                    if (!hwrite_q) m_rdata_d = Hrdata;
                end else if (cnt_q == '0) begin
                    state_d  = ST_GAP;
                    cnt_d    = GAP_LOAD;
                    m_done_d = win_q ? 2'b10 : 2'b01;
                    m_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_REJECT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            win_q      <= 1'b0;
            hwrite_q   <= 1'b0;
            hreadyin_q <= 1'b0;
            haddr_q    <= '0;
            hwdata_q   <= '0;
            m_gnt_q    <= 2'b00;
            m_done_q   <= 2'b00;
            m_err_q    <= 1'b0;
            m_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            win_q      <= win_d;
            hwrite_q   <= hwrite_d;
            hreadyin_q <= hreadyin_d;
            haddr_q    <= haddr_d;
            hwdata_q   <= hwdata_d;
            m_gnt_q    <= m_gnt_d;
            m_done_q   <= m_done_d;
            m_err_q    <= m_err_d;
            m_rdata_q  <= m_rdata_d;
        end
    end

    assign m_gnt    = m_gnt_q;
    assign m_done   = m_done_q;
    assign m_err    = m_err_q;
    assign m_rdata  = m_rdata_q;
    assign Hwrite   = hwrite_q;
    assign Hreadyin = hreadyin_q;
    assign Haddr    = haddr_q;
    assign Hwdata   = hwdata_q;
    assign Htrans   = HTRANS_NONSEQ;

endmodule
